dmem_copy_engine: RTL
=====================

# dmem_copy_engine

Word-oriented copy/fill initiator that drives the single-port data memory (`dmem`) interface: it generates `we`, `a` and `wd`, and consumes `rd`. Given a start pulse, it copies `len` words from `src` to `dst`, or fills `len` words at `dst` with a constant. It sits beside the ARM single-cycle core as a memory-side helper and owns the dmem port while `busy` is high. Arbitration with the core is external to this block.

## Interface
- `LEN_W`, 16: width of the word-count input.
- `clk` in 1: clock; all state changes on the rising edge.
- `reset` in 1: one clock; reset is synchronous and active-low. Sampled on the rising edge of `clk`; `reset`=0 forces reset state.
- `start` in 1: request; sampled only in IDLE.
- `mode` in 1: 0 = copy, 1 = fill; latched with `start`.
- `src` in 32: source byte address (copy only); latched with `start`.
- `dst` in 32: destination byte address; latched with `start`.
- `len` in LEN_W: number of 32-bit words; latched with `start`.
- `fill_val` in 32: fill word (fill only); latched with `start`.
- `busy` out 1: high from the cycle after an accepted start until the last write cycle, inclusive.
- `done` out 1: one-cycle pulse at the end of every accepted request, including error and zero-length cases.
- `err` out 1: misalignment flag; sticky until the next accepted start.
- `mem_we` out 1: dmem write enable.
- `mem_a` out 32: dmem byte address; always word-aligned.
- `mem_wd` out 32: dmem write data.
- `mem_rd` in 32: dmem read data; combinational from `mem_a`, same cycle.

## Operation
- dmem contract: combinational read, `mem_rd` = word at `mem_a` within the same cycle. Write is committed on the rising edge when `mem_we`=1.
- States: IDLE, READ, WRITE, DONE.
- Reset state: IDLE. Outputs in reset: `busy`=0, `done`=0, `err`=0, `mem_we`=0, `mem_a`=0, `mem_wd`=0. Word index `i`=0.
- **IDLE**: outputs as in reset, except `err` holds its value. When `start`=1:
  - latch all request inputs and clear `err`;
  - if misaligned (`dst[1:0]`≠0, or `mode`=0 and `src[1:0]`≠0): set `err`=1 and go to DONE; no memory access occurs;
  - else if `len`=0: go to DONE;
  - else go to READ if copy, WRITE if fill.
- **READ** (copy only):
  - drive `mem_a`=src+4·i, `mem_we`=0;
  - capture `mem_rd` into a data register at the rising edge;
  - go to WRITE.
- **WRITE**:
  - drive `mem_a`=dst+4·i, `mem_we`=1;
  - `mem_wd` = captured data (copy) or latched `fill_val` (fill);
  - at the rising edge, increment `i`;
  - if `i`+1 = `len`, go to DONE; otherwise go to READ (copy) or stay in WRITE (fill).
- **DONE**: `done`=1, `busy`=0, `mem_we`=0; go to IDLE.
- Address arithmetic is 32-bit modulo 2^32. Wrap past 0xFFFFFFFC continues at 0x00000000 with no error.
- Overlapping copies run strictly forward, one word at a time, read-then-write.
  - Example: `dst`=`src`+4 replicates word src[0] across the whole range. This is the required behavior, not a defect.
- `start` while not in IDLE is ignored and not queued.
- `reset`=0 in any state aborts at that edge: state returns to IDLE and outputs to their reset values. Writes already committed remain in memory; no further writes occur.

## Timing
- Accept edge: the rising edge where state is IDLE and `start`=1. `busy` rises in the following cycle.
- Copy, `len`=N>0: 2N busy cycles (READ/WRITE alternating), then one DONE cycle. `done` is asserted 2N+1 cycles after the accept edge.
- Fill, `len`=N>0: N busy WRITE cycles, then DONE. `done` is asserted N+1 cycles after the accept edge.
- Zero-length or error request: zero busy cycles; `done` is asserted in the cycle immediately after the accept edge.
- Minimum spacing between requests: a new `start` is accepted at the earliest in the cycle after DONE.
- `mem_we` is never asserted outside WRITE.
- `mem_a`/`mem_wd` are registered-state-derived: stable for the whole cycle, with no dependence on `mem_rd` in the same cycle.

## Test plan
- **Fill**: mode=1, dst=100, len=3, fill_val=66.
  - Required: exactly 3 write cycles, at addresses 100, 104, 108, with `mem_wd`=66.
  - Required: `done` pulses 4 cycles after accept; dmem words at 100/104/108 read back 66.
- **Copy**: preload dmem[0]=1, dmem[4]=77; mode=0, src=0, dst=200, len=2.
  - Required `mem_a` sequence: 0, 200, 4, 204, with `mem_we` pattern 0,1,0,1.
  - Required: dmem[200]=1, dmem[204]=77; `done` 5 cycles after accept.
- **Misaligned**: src=1, dst=100, mode=0, len=4.
  - Required: no `mem_we`; `busy` stays 0; `done` the next cycle; `err`=1 until the next start.
  - Then issue a valid fill and confirm `err` clears at accept.
- **Edge cases**:
  - len=0 → `done` the next cycle, no memory access.
  - `start` pulsed while busy → ignored; the request in progress completes unchanged.
- **Wrap-around**: fill at dst=0xFFFFFFF8, len=3 → writes at 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
- **Reset mid-operation**: copy with len=8; drive `reset`=0 during the 5th busy cycle.
  - Required: at that edge, state returns to IDLE and all outputs go to zero; only words 0–1 were written.
  - Required: no `done` pulse; a new request then runs normally.

Source files
------------

// File: rtl/dmem_copy_engine.sv
// dmem_copy_engine: word copy/fill initiator that drives the single-port dmem.
//
// A start pulse in IDLE latches a request. The engine then either copies len
// words from src to dst as alternating read/write cycles, or fills len words
// at dst with fill_val, one write per cycle. While busy is high the engine
// owns the dmem port. Arbitration with the core is handled outside this block.
//
// Ports
//   clk       rising-edge clock
//   reset     synchronous, active-low
//   start     request strobe, sampled only in IDLE
//   mode      0 = copy, 1 = fill
//   src/dst   source/destination byte addresses (must be word aligned)
//   len       word count
//   fill_val  fill word
//   busy      request in progress (READ/WRITE cycles)
//   done      one-cycle completion pulse for every accepted request
//   err       misalignment flag, sticky until the next accepted start
//   mem_we    dmem write enable
//   mem_a     dmem byte address
//   mem_wd    dmem write data
//   mem_rd    dmem read data, combinational from mem_a
module dmem_copy_engine #(
  parameter int unsigned LEN_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             mode,
  input  logic [31:0]      src,
  input  logic [31:0]      dst,
  input  logic [LEN_W-1:0] len,
  input  logic [31:0]      fill_val,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             mem_we,
  output logic [31:0]      mem_a,
  output logic [31:0]      mem_wd,
  input  logic [31:0]      mem_rd
);

  localparam int unsigned AW = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state;
  logic             mode_q;
  logic [AW-1:0]    src_q;
  logic [AW-1:0]    dst_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] idx;

  logic [LEN_W-1:0] idx_nxt;
  logic             last_word;
  logic             misaligned;

  // Byte address of word k relative to base; wraps modulo 2^32.
  function automatic logic [AW-1:0] word_addr(input logic [AW-1:0]    base,
                                              input logic [LEN_W-1:0] k);
    return base + (AW'(k) << 2);
  endfunction

  assign idx_nxt    = idx + LEN_W'(1);
  assign last_word  = (idx_nxt == len_q);
  // Source alignment only matters for copies.
  assign misaligned = (dst[1:0] != 2'b00) || (!mode && (src[1:0] != 2'b00));

  // Single-process FSM. Every output is a register loaded with the value it
  // must carry in the state being entered, so mem_a/mem_wd never depend on
  // mem_rd within the same cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
      mem_we <= 1'b0;
      mem_a  <= '0;
      mem_wd <= '0;
      idx    <= '0;
      mode_q <= 1'b0;
      src_q  <= '0;
      dst_q  <= '0;
      len_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          busy   <= 1'b0;
          done   <= 1'b0;
          mem_we <= 1'b0;
          mem_a  <= '0;
          mem_wd <= '0;
          idx    <= '0;
          if (start) begin
            mode_q <= mode;
            src_q  <= src;
            dst_q  <= dst;
            len_q  <= len;
            err    <= misaligned;
            if (misaligned || (len == '0)) begin
              // No memory access: straight to the completion pulse.
              state <= DONE;
              done  <= 1'b1;
            end else if (mode) begin
              state  <= WRITE;
              busy   <= 1'b1;
              mem_we <= 1'b1;
              mem_a  <= dst;
              mem_wd <= fill_val;
            end else begin
              state <= READ;
              busy  <= 1'b1;
              mem_a <= src;
            end
          end
        end

        READ: begin
          // Capture the source word directly into the write-data register.
          state  <= WRITE;
          mem_we <= 1'b1;
          mem_a  <= word_addr(dst_q, idx);
          mem_wd <= mem_rd;
        end

        WRITE: begin
          idx <= idx_nxt;
          if (last_word) begin
            state  <= DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
            mem_we <= 1'b0;
            mem_a  <= '0;
            mem_wd <= '0;
          end else if (mode_q) begin
            // Fill: stay in WRITE, mem_wd keeps the fill word.
            mem_a <= word_addr(dst_q, idx_nxt);
          end else begin
            state  <= READ;
            mem_we <= 1'b0;
            mem_a  <= word_addr(src_q, idx_nxt);
          end
        end

        DONE: begin
          state  <= IDLE;
          done   <= 1'b0;
          busy   <= 1'b0;
          mem_we <= 1'b0;
          mem_a  <= '0;
          mem_wd <= '0;
          idx    <= '0;
        end

        default: begin
          state  <= IDLE;
          busy   <= 1'b0;
          done   <= 1'b0;
          mem_we <= 1'b0;
          mem_a  <= '0;
          mem_wd <= '0;
          idx    <= '0;
        end
      endcase
    end
  end

endmodule
